// File: rtl/mem_ctrl_burst.sv
// Byte-serial memory controller: arbitrates a data port (1/2/4-byte load/store) and an
// instruction-line port onto an 8-bit RAM whose read data arrives one cycle after the address.
module mem_ctrl_burst #(
    parameter int LINE_WORDS    = 4,
    parameter int DATA_PRIORITY = 1
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     jump_or_not_in,
    input  logic                     mem_enable_in,
    input  logic                     mem_read_or_write_in,
    input  logic [2:0]               mem_width_in,
    input  logic [31:0]              mem_address_in,
    input  logic [31:0]              mem_target_data_in,
    output logic                     mem_enable_out,
    output logic [31:0]              mem_rdata_out,
    output logic                     mem_busy_out,
    input  logic                     inst_enable_in,
    input  logic [31:0]              inst_address_in,
    output logic                     inst_enable_out,
    output logic [32*LINE_WORDS-1:0] inst_data_out,
    output logic                     inst_busy_out,
    input  logic [7:0]               ram_data_in,
    output logic [7:0]               ram_data_out,
    output logic [31:0]              ram_address_out,
    output logic                     ram_wr,
    input  logic                     io_buffer_full
);
    localparam int          NB        = 4 * LINE_WORDS;
    localparam int          BW        = 32 * LINE_WORDS;
    localparam logic [5:0]  NB_L      = 6'(NB);
    localparam logic [31:0] LINE_MASK = ~32'(NB - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_DATA_RD = 3'd1;
    localparam logic [2:0] S_DATA_WR = 3'd2;
    localparam logic [2:0] S_INST_RD = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [5:0]    idx_q, idx_d;
    logic [5:0]    n_q, n_d;
    logic [31:0]   base_q, base_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          inst_q, inst_d;
    logic [BW-1:0] buf_q, buf_d;
    logic [BW-1:0] idata_q, idata_d;

    logic [31:0] byte_addr;
    logic [7:0]  wbyte;
    logic        io_stall;
    logic        take_data;
    logic        take_inst;

    assign byte_addr = base_q + {26'd0, idx_q};
    assign io_stall  = (byte_addr[17:16] == 2'b11) && io_buffer_full;
    assign take_data = mem_enable_in && (!inst_enable_in || (DATA_PRIORITY != 0));
    assign take_inst = inst_enable_in && !take_data;

    assign mem_rdata_out = rdata_q;
    assign inst_data_out = idata_q;

    always_comb begin
        wbyte = wdata_q[7:0];
        case (idx_q[1:0])
            2'd1:    wbyte = wdata_q[15:8];
            2'd2:    wbyte = wdata_q[23:16];
            2'd3:    wbyte = wdata_q[31:24];
            default: wbyte = wdata_q[7:0];
        endcase
    end

    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        n_d             = n_q;
        base_d          = base_q;
        wdata_d         = wdata_q;
        inst_d          = inst_q;
        buf_d           = buf_q;
        rdata_d         = rdata_q;
        idata_d         = idata_q;
        ram_address_out = '0;
        ram_data_out    = '0;
        ram_wr          = 1'b0;
        mem_enable_out  = 1'b0;
        inst_enable_out = 1'b0;
        mem_busy_out    = 1'b0;
        inst_busy_out   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (take_data) begin
                    state_d = mem_read_or_write_in ? S_DATA_WR : S_DATA_RD;
                    base_d  = mem_address_in;
                    wdata_d = mem_target_data_in;
                    inst_d  = 1'b0;
                    idx_d   = '0;
                    buf_d   = '0;
                    case (mem_width_in)
                        3'd1:    n_d = 6'd1;
                        3'd2:    n_d = 6'd2;
                        default: n_d = 6'd4;
                    endcase
                end else if (take_inst) begin
                    state_d = S_INST_RD;
                    base_d  = inst_address_in & LINE_MASK;
                    wdata_d = '0;
                    inst_d  = 1'b1;
                    idx_d   = '0;
                    n_d     = NB_L;
                    buf_d   = '0;
                end
            end
            S_DATA_RD, S_INST_RD: begin
                mem_busy_out  = (state_q == S_DATA_RD);
                inst_busy_out = (state_q == S_INST_RD);
                if (idx_q != n_q) ram_address_out = byte_addr;
                // RAM answers one cycle late: this cycle's ram_data_in is byte idx-1
                for (int k = 0; k < NB; k++) begin
                    if (idx_q == 6'(k + 1)) buf_d[8*k +: 8] = ram_data_in;
                end
                if (idx_q == n_q) begin
                    state_d = S_DONE;
                    if (inst_q) idata_d = buf_d;
                    else        rdata_d = buf_d[31:0];
                end else begin
                    idx_d = idx_q + 6'd1;
                end
                if (inst_q && jump_or_not_in) begin
                    state_d = S_IDLE;
                    idata_d = idata_q;
                end
            end
            S_DATA_WR: begin
                mem_busy_out = 1'b1;
                if (!io_stall) begin
                    ram_wr          = 1'b1;
                    ram_address_out = byte_addr;
                    ram_data_out    = wbyte;
                    if (idx_q == n_q - 6'd1) state_d = S_DONE;
                    else                     idx_d   = idx_q + 6'd1;
                end
            end
            S_DONE: begin
                mem_enable_out  = !inst_q;
                inst_enable_out = inst_q;
                state_d         = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            n_q     <= '0;
            base_q  <= '0;
            wdata_q <= '0;
            inst_q  <= 1'b0;
            buf_q   <= '0;
            rdata_q <= '0;
            idata_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            n_q     <= n_d;
            base_q  <= base_d;
            wdata_q <= wdata_d;
            inst_q  <= inst_d;
            buf_q   <= buf_d;
            rdata_q <= rdata_d;
            idata_q <= idata_d;
        end
    end

endmodule

// File: tb/tb_mem_ctrl_burst.sv
// Cycle-stepped bench: a byte RAM model with one-cycle read latency, per-cycle stimulus
// vectors, and expectations derived from byte counts, stall patterns and RAM contents.
module tb_mem_ctrl_burst;
    localparam int MAXC = 64;

    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic          rst_in, jump_or_not_in, mem_enable_in, mem_read_or_write_in;
    logic [2:0]    mem_width_in;
    logic [31:0]   mem_address_in, mem_target_data_in, inst_address_in;
    logic          inst_enable_in, io_buffer_full;
    logic [7:0]    ram_data_in;
    logic          mem_enable_out, mem_busy_out, inst_enable_out, inst_busy_out, ram_wr;
    logic [31:0]   mem_rdata_out, ram_address_out;
    logic [127:0]  inst_data_out;
    logic [7:0]    ram_data_out;
    logic          b_mem_enable_out, b_mem_busy_out, b_inst_enable_out, b_inst_busy_out, b_ram_wr;
    logic [31:0]   b_mem_rdata_out, b_ram_address_out;
    logic [127:0]  b_inst_data_out;
    logic [7:0]    b_ram_data_out;

    mem_ctrl_burst #(.LINE_WORDS(4), .DATA_PRIORITY(1)) u_dut (
        .clk_in(clk_in), .rst_in(rst_in), .jump_or_not_in(jump_or_not_in),
        .mem_enable_in(mem_enable_in), .mem_read_or_write_in(mem_read_or_write_in),
        .mem_width_in(mem_width_in), .mem_address_in(mem_address_in),
        .mem_target_data_in(mem_target_data_in), .mem_enable_out(mem_enable_out),
        .mem_rdata_out(mem_rdata_out), .mem_busy_out(mem_busy_out),
        .inst_enable_in(inst_enable_in), .inst_address_in(inst_address_in),
        .inst_enable_out(inst_enable_out), .inst_data_out(inst_data_out),
        .inst_busy_out(inst_busy_out), .ram_data_in(ram_data_in), .ram_data_out(ram_data_out),
        .ram_address_out(ram_address_out), .ram_wr(ram_wr), .io_buffer_full(io_buffer_full)
    );

    // Instruction-priority variant shares every input; only used for arbitration order
    mem_ctrl_burst #(.LINE_WORDS(4), .DATA_PRIORITY(0)) u_dut_ip (
        .clk_in(clk_in), .rst_in(rst_in), .jump_or_not_in(jump_or_not_in),
        .mem_enable_in(mem_enable_in), .mem_read_or_write_in(mem_read_or_write_in),
        .mem_width_in(mem_width_in), .mem_address_in(mem_address_in),
        .mem_target_data_in(mem_target_data_in), .mem_enable_out(b_mem_enable_out),
        .mem_rdata_out(b_mem_rdata_out), .mem_busy_out(b_mem_busy_out),
        .inst_enable_in(inst_enable_in), .inst_address_in(inst_address_in),
        .inst_enable_out(b_inst_enable_out), .inst_data_out(b_inst_data_out),
        .inst_busy_out(b_inst_busy_out), .ram_data_in(ram_data_in), .ram_data_out(b_ram_data_out),
        .ram_address_out(b_ram_address_out), .ram_wr(b_ram_wr), .io_buffer_full(io_buffer_full)
    );

    logic [MAXC-1:0] s_rst, s_men, s_ien, s_full, s_jump;
    logic [MAXC-1:0] t_men, t_ien, t_mbusy, t_ibusy, t_wr, tb_ibusy, tb_mbusy;
    logic [31:0]     t_addr [MAXC];
    logic [7:0]      t_wd   [MAXC];
    logic [31:0]     tb_addr[MAXC];
    logic [255:0]    t_all  [MAXC];
    logic [7:0]      ram [bit [31:0]];
    logic [31:0]     prev_addr;
    logic [31:0]     last_rdata;
    logic [127:0]    last_idata;
    int              n_chk, n_pass, n_fail;

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        if (ram.exists(a)) return ram[a];
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'h5A;
    endfunction

    function automatic logic [63:0] rng(input int lo, input int hi);
        logic [63:0] m = '0;
        for (int i = 0; i < 64; i++) if (i >= lo && i <= hi) m[i] = 1'b1;
        return m;
    endfunction

    function automatic int nbytes(input logic [2:0] w);
        return (w == 3'd1) ? 1 : (w == 3'd2) ? 2 : 4;
    endfunction

    function automatic logic [127:0] line_of(input logic [31:0] base);
        logic [127:0] v = '0;
        for (int k = 0; k < 16; k++) v[8*k +: 8] = ram_rd(base + 32'(k));
        return v;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle per iteration: drive at posedge+1, sample at negedge, RAM answers a cycle later
    task automatic run(input int nc);
        t_men = '0; t_ien = '0; t_mbusy = '0; t_ibusy = '0; t_wr = '0; tb_ibusy = '0; tb_mbusy = '0;
        for (int c = 0; c < nc; c++) begin
            rst_in         = s_rst[c];
            mem_enable_in  = s_men[c];
            inst_enable_in = s_ien[c];
            io_buffer_full = s_full[c];
            jump_or_not_in = s_jump[c];
            ram_data_in    = ram_rd(prev_addr);
            @(negedge clk_in);
            t_addr[c]   = ram_address_out;
            t_wd[c]     = ram_data_out;
            t_wr[c]     = ram_wr;
            t_men[c]    = mem_enable_out;
            t_ien[c]    = inst_enable_out;
            t_mbusy[c]  = mem_busy_out;
            t_ibusy[c]  = inst_busy_out;
            tb_ibusy[c] = b_inst_busy_out;
            tb_mbusy[c] = b_mem_busy_out;
            tb_addr[c]  = b_ram_address_out;
            t_all[c]    = 256'({mem_enable_out, mem_rdata_out, mem_busy_out, inst_enable_out,
                                 inst_data_out, inst_busy_out, ram_data_out, ram_address_out, ram_wr});
            if (ram_wr) ram[ram_address_out] = ram_data_out;
            prev_addr = ram_address_out;
            @(posedge clk_in);
            #1;
        end
        rst_in = 1'b0; mem_enable_in = 1'b0; inst_enable_in = 1'b0;
        io_buffer_full = 1'b0; jump_or_not_in = 1'b0;
        s_rst = '0; s_men = '0; s_ien = '0; s_full = '0; s_jump = '0;
    endtask

    task automatic do_read(input logic [31:0] a, input logic [2:0] w);
        int n = nbytes(w);
        int mis = 0;
        logic [31:0] exp = '0;
        for (int k = 0; k < n; k++) exp[8*k +: 8] = ram_rd(a + 32'(k));
        mem_read_or_write_in = 1'b0; mem_width_in = w; mem_address_in = a;
        mem_target_data_in = $urandom;
        s_men[0] = 1'b1;
        for (int c = 1; c < n + 5; c++) s_jump[c] = 1'($urandom_range(0, 1));
        run(n + 5);
        for (int c = 0; c < n + 5; c++)
            if (t_addr[c] !== ((c >= 1 && c <= n) ? a + 32'(c - 1) : 32'd0)) mis++;
        chk("rd_addr_trace", 256'(mis), 256'(0));
        chk("rd_no_wr", 256'(t_wr), 256'(0));
        chk("rd_busy", 256'(t_mbusy), 256'(rng(1, n + 1)));
        chk("rd_done_pulse", 256'(t_men), 256'(rng(n + 2, n + 2)));
        chk("rd_data", 256'(mem_rdata_out), 256'(exp));
        last_rdata = exp;
    endtask

    // Caller presets s_full; the model walks bytes, skipping stalled I/O cycles
    task automatic do_write(input logic [31:0] a, input logic [2:0] w, input logic [31:0] d);
        int n = nbytes(w);
        int k = 0;
        int c = 1;
        int mis = 0;
        logic [63:0] ew = '0;
        logic [31:0] ea[MAXC];
        logic [7:0]  ed[MAXC];
        logic [31:0] ba;
        for (int i = 0; i < MAXC; i++) begin ea[i] = '0; ed[i] = '0; end
        while (k < n) begin
            ba = a + 32'(k);
            if (!(ba[17:16] == 2'b11 && s_full[c])) begin
                ew[c] = 1'b1; ea[c] = ba; ed[c] = d[8*k +: 8]; k++;
            end
            c++;
        end
        mem_read_or_write_in = 1'b1; mem_width_in = w; mem_address_in = a; mem_target_data_in = d;
        s_men[0] = 1'b1;
        for (int j = 1; j < c + 3; j++) s_jump[j] = 1'($urandom_range(0, 1));
        run(c + 3);
        for (int j = 0; j < c + 3; j++) if (t_addr[j] !== ea[j] || t_wd[j] !== ed[j]) mis++;
        chk("wr_addr_data_trace", 256'(mis), 256'(0));
        chk("wr_strobes", 256'(t_wr), 256'(ew));
        chk("wr_busy", 256'(t_mbusy), 256'(rng(1, c - 1)));
        chk("wr_done_pulse", 256'(t_men), 256'(rng(c, c)));
        chk("wr_rdata_hold", 256'(mem_rdata_out), 256'(last_rdata));
    endtask

    task automatic do_inst(input logic [31:0] a);
        logic [31:0]  base = a & 32'hFFFF_FFF0;
        logic [127:0] exp  = line_of(base);
        int mis = 0;
        inst_address_in = a;
        s_ien[0] = 1'b1;
        run(21);
        for (int c = 0; c < 21; c++)
            if (t_addr[c] !== ((c >= 1 && c <= 16) ? base + 32'(c - 1) : 32'd0)) mis++;
        chk("if_addr_trace", 256'(mis), 256'(0));
        chk("if_busy", 256'(t_ibusy), 256'(rng(1, 17)));
        chk("if_done_pulse", 256'(t_ien), 256'(rng(18, 18)));
        chk("if_data", 256'(inst_data_out), 256'(exp));
        chk("if_mem_quiet", 256'({t_mbusy, t_men, t_wr}), 256'(0));
        last_idata = exp;
    endtask

    initial begin
        logic [31:0]  a;
        logic [31:0]  expd;
        logic [127:0] expi;
        int           mis;
        n_chk = 0; n_pass = 0; n_fail = 0;
        rst_in = 1'b1; jump_or_not_in = 1'b0; mem_enable_in = 1'b0; mem_read_or_write_in = 1'b0;
        mem_width_in = 3'd0; mem_address_in = '0; mem_target_data_in = '0;
        inst_enable_in = 1'b0; inst_address_in = '0; io_buffer_full = 1'b0; ram_data_in = '0;
        s_rst = '0; s_men = '0; s_ien = '0; s_full = '0; s_jump = '0;
        prev_addr = '0; last_rdata = '0; last_idata = '0;
        @(posedge clk_in);
        #1;

        // Reset state
        s_rst[2:0] = 3'b111;
        run(3);
        mis = 0;
        for (int c = 0; c < 3; c++) if (t_all[c] !== 256'd0) mis++;
        chk("reset_outputs_zero", 256'(mis), 256'(0));

        // Simultaneous requests on the first cycle out of reset
        expd = {ram_rd(32'h203), ram_rd(32'h202), ram_rd(32'h201), ram_rd(32'h200)};
        expi = line_of(32'h3000);
        mem_read_or_write_in = 1'b0; mem_width_in = 3'd4; mem_address_in = 32'h200;
        inst_address_in = 32'h3008;
        s_men[0] = 1'b1; s_ien[7:0] = 8'hFF;
        run(27);
        chk("pri_data_first", 256'({t_mbusy[1], t_ibusy[1], t_addr[1]}), 256'({2'b10, 32'h200}));
        chk("pri_mem_done", 256'(t_men), 256'(rng(6, 6)));
        chk("pri_inst_after", 256'({t_ibusy[8], t_addr[8]}), 256'({1'b1, 32'h3000}));
        chk("pri_inst_done", 256'(t_ien), 256'(rng(25, 25)));
        chk("pri_rdata", 256'(mem_rdata_out), 256'(expd));
        chk("pri_idata", 256'(inst_data_out), 256'(expi));
        chk("pri0_inst_first", 256'({tb_ibusy[1], tb_mbusy[1], tb_addr[1]}), 256'({2'b10, 32'h3000}));
        last_rdata = expd; last_idata = expi;

        // LW with known bytes
        ram[32'h100] = 8'h11; ram[32'h101] = 8'h22; ram[32'h102] = 8'h33; ram[32'h103] = 8'h44;
        do_read(32'h0000_0100, 3'd4);
        chk("lw_value", 256'(mem_rdata_out), 256'(32'h4433_2211));
        chk("lw_pulse_cycle6", 256'(t_men), 256'(64'h40));

        // Widths, odd width code, address wrap
        do_read(32'h0000_0123, 3'd1);
        do_read(32'h0000_0456, 3'd2);
        do_read(32'h0000_0789, 3'd7);
        do_read(32'hFFFF_FFFE, 3'd4);

        // Byte store to I/O space with the buffer full for cycles 1-3
        s_full[3:1] = 3'b111;
        do_write(32'h0003_0000, 3'd1, 32'h0000_00AB);
        chk("sb_io_strobe", 256'(t_wr), 256'(64'h10));
        chk("sb_io_data", 256'(t_wd[4]), 256'(8'hAB));
        chk("sb_io_done", 256'(t_men), 256'(64'h20));

        // Instruction line fetch from a mid-line address
        do_inst(32'h0000_1014);
        chk("if_first_addr", 256'(t_addr[1]), 256'(32'h1010));
        chk("if_last_addr", 256'(t_addr[16]), 256'(32'h101F));
        chk("if_word0", 256'(inst_data_out[31:0]),
            256'({ram_rd(32'h1013), ram_rd(32'h1012), ram_rd(32'h1011), ram_rd(32'h1010)}));

        // Branch flush in cycle 5 with a data request pending
        expd = {ram_rd(32'h503), ram_rd(32'h502), ram_rd(32'h501), ram_rd(32'h500)};
        mem_read_or_write_in = 1'b0; mem_width_in = 3'd4; mem_address_in = 32'h500;
        inst_address_in = 32'h4000;
        s_ien[0] = 1'b1; s_jump[5] = 1'b1; s_men[6:2] = 5'h1F;
        run(15);
        mis = 0;
        for (int c = 1; c <= 5; c++) if (t_addr[c] !== 32'h4000 + 32'(c - 1)) mis++;
        chk("ab_inst_addrs", 256'(mis), 256'(0));
        chk("ab_no_inst_pulse", 256'(t_ien), 256'(0));
        chk("ab_idle_c6", 256'({t_ibusy[6], t_mbusy[6], t_addr[6]}), 256'(0));
        chk("ab_data_accept", 256'({t_mbusy[7], t_addr[7]}), 256'({1'b1, 32'h500}));
        chk("ab_data_done", 256'(t_men), 256'(rng(12, 12)));
        chk("ab_rdata", 256'(mem_rdata_out), 256'(expd));
        chk("ab_idata_hold", 256'(inst_data_out), 256'(last_idata));
        last_rdata = expd;

        // Randomized mix of reads, stalled writes and line fetches
        for (int i = 0; i < 12; i++) begin
            case (i % 3)
                0: do_read($urandom, 3'($urandom_range(0, 7)));
                1: begin
                    a = $urandom;
                    if ($urandom_range(0, 1) == 1) a = {a[31:18], 2'b11, 4'h0, a[11:0]};
                    for (int c = 0; c < 20; c++) s_full[c] = 1'($urandom_range(0, 1));
                    do_write(a, 3'($urandom_range(0, 7)), $urandom);
                end
                default: do_inst($urandom);
            endcase
        end

        // Reset in cycle 3 of a word store
        mem_read_or_write_in = 1'b1; mem_width_in = 3'd4; mem_address_in = 32'h2000;
        mem_target_data_in = $urandom;
        s_men[0] = 1'b1; s_rst[3] = 1'b1;
        run(8);
        mis = 0;
        for (int c = 4; c < 8; c++) if (t_all[c] !== 256'd0) mis++;
        chk("rst_mid_strobes", 256'(t_wr), 256'(rng(1, 3)));
        chk("rst_mid_no_pulse", 256'(t_men), 256'(0));
        chk("rst_mid_outputs_zero", 256'(mis), 256'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
